// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the crossbar sockets, plus the
// outstanding-counter width used by tlul_socket_m1_ot.
package tlul_pkg;

   localparam int unsigned IDW = 8;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;

   // Per-host in-flight counter width; caps MaxOutstanding at 15.
   localparam int unsigned SocketCntW = 4;
   typedef logic [SocketCntW-1:0] socket_cnt_t;

   typedef struct packed {
      logic            a_valid;
      logic [2:0]      a_opcode;
      logic [2:0]      a_param;
      logic [1:0]      a_size;
      logic [IDW-1:0]  a_source;
      logic [AW-1:0]   a_address;
      logic [DW/8-1:0] a_mask;
      logic [DW-1:0]   a_data;
      logic            d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic           d_valid;
      logic [2:0]     d_opcode;
      logic [2:0]     d_param;
      logic [1:0]     d_size;
      logic [IDW-1:0] d_source;
      logic           d_sink;
      logic [DW-1:0]  d_data;
      logic           d_error;
      logic           a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_socket_rr_arb.sv
// Request arbiter for tlul_socket_m1_ot: round-robin (or fixed priority,
// host 0 highest) over an eligibility vector. A winner that is presented
// but not accepted is locked until its handshake so the A channel stays
// stable.
module tlul_socket_rr_arb #(
   parameter int unsigned M         = 4,
   parameter bit          FixedPrio = 1'b0,
   localparam int unsigned IW       = $clog2(M)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [M-1:0]  elig_i,
   input  logic          accept_i,
   output logic          valid_o,
   output logic [IW-1:0] sel_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] sel_q, sel_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] pick;
   logic          any_elig;
   int unsigned   start;
   int unsigned   idx;

   // First eligible host at or after the search start, wrapping past M-1
   always_comb begin
      pick     = '0;
      any_elig = 1'b0;
      idx      = 0;
      start    = FixedPrio ? 0 : 32'(ptr_q);
      for (int unsigned k = 0; k < M; k++) begin
         idx = start + k;
         if (idx >= M) idx = idx - M;
         if (!any_elig && elig_i[idx]) begin
            any_elig = 1'b1;
            pick     = IW'(idx);
         end
      end
   end

   assign sel_o   = lock_q ? sel_q : pick;
   assign valid_o = lock_q | any_elig;

   // Lock a stalled winner; advance the pointer past the winner on handshake
   always_comb begin
      lock_d = lock_q;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      if (valid_o && !accept_i) begin
         lock_d = 1'b1;
         sel_d  = sel_o;
      end
      if (accept_i) begin
         lock_d = 1'b0;
         ptr_d  = (sel_o == IW'(M - 1)) ? '0 : sel_o + 1'b1;
      end
   end

   // Arbiter state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q  <= '0;
         sel_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         sel_q  <= sel_d;
         lock_q <= lock_d;
      end
   end

endmodule

// File: rtl/tlul_socket_m1_ot.sv
// M:1 TL-UL socket with per-host outstanding caps, an optional A-channel
// pipeline register and source-ID based response routing.
// Optional feature macro: TLUL_SOCKET_M1_OT_PERF_EN adds perf_stall_o,
// per-host saturating 16-bit counts of stalled request cycles.
module tlul_socket_m1_ot
   import tlul_pkg::*;
#(
   parameter int unsigned M              = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter bit          ReqReg         = 1'b0,
   parameter bit          ArbFixedPrio   = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  tl_h2d_t                 tl_h_i [M],
   output tl_d2h_t                 tl_h_o [M],
   output tl_h2d_t                 tl_d_o,
   input  tl_d2h_t                 tl_d_i,
   output logic [M*SocketCntW-1:0] outstanding_o,
   output logic                    idle_o,
   output logic                    err_bad_id_o
`ifdef TLUL_SOCKET_M1_OT_PERF_EN
   ,
   output logic [M*16-1:0]         perf_stall_o
`endif
);

   localparam int unsigned STIDW = $clog2(M);

   logic [M-1:0]     elig;
   logic [M-1:0]     a_hs;
   logic [M-1:0]     d_hs;
   logic [STIDW-1:0] sel;
   logic             arb_valid;
   logic             arb_accept;
   logic             down_ready;
   logic             full;
   tl_h2d_t          fwd_req;
   logic [STIDW-1:0] rsp_idx;
   logic             bad_id;
   logic             rsp_ready;
   socket_cnt_t      cnt_q [M];
   socket_cnt_t      cnt_d [M];
   logic             err_q, err_d;

   // A host competes only while below its in-flight cap
   always_comb begin
      elig = '0;
      for (int unsigned k = 0; k < M; k++) begin
         elig[k] = tl_h_i[k].a_valid & (cnt_q[k] < SocketCntW'(MaxOutstanding));
      end
   end

   tlul_socket_rr_arb #(
      .M         (M),
      .FixedPrio (ArbFixedPrio)
   ) u_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .elig_i   (elig),
      .accept_i (arb_accept),
      .valid_o  (arb_valid),
      .sel_o    (sel)
   );

   assign arb_accept = arb_valid & down_ready;

   // Selected request with the host index appended to the source ID
   always_comb begin
      fwd_req = tl_h_i[0];
      for (int unsigned k = 1; k < M; k++) begin
         if (sel == STIDW'(k)) fwd_req = tl_h_i[k];
      end
      fwd_req.a_valid  = arb_valid;
      fwd_req.a_source = {fwd_req.a_source[IDW-STIDW-1:0], sel};
      fwd_req.d_ready  = rsp_ready;
   end

   if (ReqReg) begin : g_req_reg
      tl_h2d_t req_q, req_d;
      logic    full_q, full_d;

      // One-entry slot: refill in the same cycle it drains for full rate
      always_comb begin
         req_d  = req_q;
         full_d = full_q & ~tl_d_i.a_ready;
         if (arb_accept) begin
            req_d  = fwd_req;
            full_d = 1'b1;
         end
      end

      // Request register
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            req_q  <= '0;
            full_q <= 1'b0;
         end else begin
            req_q  <= req_d;
            full_q <= full_d;
         end
      end

      assign full       = full_q;
      assign down_ready = ~full_q | tl_d_i.a_ready;

      // Device A channel from the register; d_ready stays combinational
      always_comb begin
         tl_d_o         = req_q;
         tl_d_o.a_valid = full_q;
         tl_d_o.d_ready = rsp_ready;
      end
   end else begin : g_no_req_reg
      assign full       = 1'b0;
      assign down_ready = tl_d_i.a_ready;
      assign tl_d_o     = fwd_req;
   end

   // Route D by low source bits; unknown IDs are swallowed
   always_comb begin
      rsp_idx   = tl_d_i.d_source[STIDW-1:0];
      bad_id    = ({1'b0, rsp_idx} >= (STIDW + 1)'(M));
      rsp_ready = bad_id;
      a_hs      = '0;
      d_hs      = '0;
      for (int unsigned k = 0; k < M; k++) begin
         tl_h_o[k]          = tl_d_i;
         tl_h_o[k].d_valid  = tl_d_i.d_valid & (rsp_idx == STIDW'(k));
         tl_h_o[k].d_source = {{STIDW{1'b0}}, tl_d_i.d_source[IDW-1:STIDW]};
         tl_h_o[k].a_ready  = arb_accept & (sel == STIDW'(k));
         a_hs[k]            = tl_h_o[k].a_ready;
         d_hs[k]            = tl_h_o[k].d_valid & tl_h_i[k].d_ready;
         if (rsp_idx == STIDW'(k)) rsp_ready = tl_h_i[k].d_ready;
      end
   end

   // In-flight counters: A handshake adds, D handshake removes, floor at 0
   always_comb begin
      outstanding_o = '0;
      idle_o        = ~full;
      for (int unsigned k = 0; k < M; k++) begin
         cnt_d[k] = cnt_q[k];
         if (a_hs[k] && !d_hs[k]) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
         end else if (d_hs[k] && !a_hs[k] && (cnt_q[k] != '0)) begin
            cnt_d[k] = cnt_q[k] - 1'b1;
         end
         outstanding_o[k*SocketCntW +: SocketCntW] = cnt_q[k];
         if (cnt_q[k] != '0) idle_o = 1'b0;
      end
      err_d = err_q | (tl_d_i.d_valid & bad_id);
   end

   assign err_bad_id_o = err_q;

   // Counter and sticky error registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '{default: '0};
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

`ifdef TLUL_SOCKET_M1_OT_PERF_EN
   logic [15:0] stall_q [M];
   logic [15:0] stall_d [M];

   // Count cycles a host waits with a_valid high, saturating
   always_comb begin
      perf_stall_o = '0;
      for (int unsigned k = 0; k < M; k++) begin
         stall_d[k] = stall_q[k];
         if (tl_h_i[k].a_valid && !tl_h_o[k].a_ready && (stall_q[k] != 16'hFFFF)) begin
            stall_d[k] = stall_q[k] + 1'b1;
         end
         perf_stall_o[k*16 +: 16] = stall_q[k];
      end
   end

   // Stall counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '{default: '0};
      end else begin
         stall_q <= stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_tlul_socket_m1_ot.sv
// Testbench for tlul_socket_m1_ot: instance A (M=4, cap 2, no request
// register) and instance B (M=3, cap 2, request register).
module tb_tlul_socket_m1_ot;
   import tlul_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tl_h2d_t     a_h_i [4];
   tl_d2h_t     a_h_o [4];
   tl_h2d_t     a_d_o;
   tl_d2h_t     a_d_i;
   logic [15:0] a_out;
   logic        a_idle, a_err;

   tl_h2d_t     b_h_i [3];
   tl_d2h_t     b_h_o [3];
   tl_h2d_t     b_d_o;
   tl_d2h_t     b_d_i;
   logic [11:0] b_out;
   logic        b_idle, b_err;

`ifdef TLUL_SOCKET_M1_OT_PERF_EN
   logic [63:0] a_perf;
   logic [47:0] b_perf;
`endif

   tlul_socket_m1_ot #(
      .M(4), .MaxOutstanding(2), .ReqReg(1'b0), .ArbFixedPrio(1'b0)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .tl_h_i(a_h_i), .tl_h_o(a_h_o), .tl_d_o(a_d_o), .tl_d_i(a_d_i),
      .outstanding_o(a_out), .idle_o(a_idle), .err_bad_id_o(a_err)
`ifdef TLUL_SOCKET_M1_OT_PERF_EN
      , .perf_stall_o(a_perf)
`endif
   );

   tlul_socket_m1_ot #(
      .M(3), .MaxOutstanding(2), .ReqReg(1'b1), .ArbFixedPrio(1'b0)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .tl_h_i(b_h_i), .tl_h_o(b_h_o), .tl_d_o(b_d_o), .tl_d_i(b_d_i),
      .outstanding_o(b_out), .idle_o(b_idle), .err_bad_id_o(b_err)
`ifdef TLUL_SOCKET_M1_OT_PERF_EN
      , .perf_stall_o(b_perf)
`endif
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] a_exp_q [$];
   logic [7:0] b_exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Forwarded source: host ID (2 bits for M=3 and M=4) shifted in at the bottom
   function automatic logic [7:0] fwd(input logic [7:0] src, input int unsigned host);
      logic [31:0] h;
      h = host;
      return {src[5:0], h[1:0]};
   endfunction

   function automatic logic any_dv_a();
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) r |= a_h_o[i].d_valid;
      return r;
   endfunction

   function automatic logic any_dv_b();
      logic r;
      r = 1'b0;
      for (int i = 0; i < 3; i++) r |= b_h_o[i].d_valid;
      return r;
   endfunction

   // Scoreboard pop on every device-side A handshake
   task automatic mon();
      if (a_d_o.a_valid && a_d_i.a_ready) begin
         if (a_exp_q.size() == 0) check_eq("a_sb_extra", {24'b0, a_d_o.a_source}, 32'hFFFF_FFFF);
         else check_eq("a_src", {24'b0, a_d_o.a_source}, {24'b0, a_exp_q.pop_front()});
      end
      if (b_d_o.a_valid && b_d_i.a_ready) begin
         if (b_exp_q.size() == 0) check_eq("b_sb_extra", {24'b0, b_d_o.a_source}, 32'hFFFF_FFFF);
         else check_eq("b_src", {24'b0, b_d_o.a_source}, {24'b0, b_exp_q.pop_front()});
      end
   endtask

   // Called after inputs have settled: sample, then advance one cycle
   task automatic adv();
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) a_h_i[i] = '0;
      for (int i = 0; i < 3; i++) b_h_i[i] = '0;
      a_d_i = '0;
      b_d_i = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      do_reset();
      #1;
      check_eq("rst_a_valid", a_d_o.a_valid, 0);
      check_eq("rst_a_idle", a_idle, 1);
      check_eq("rst_a_out", a_out, 0);
      check_eq("rst_a_err", a_err, 0);
      check_eq("rst_a_dvalid", any_dv_a(), 0);
      check_eq("rst_b_valid", b_d_o.a_valid, 0);
      check_eq("rst_b_idle", b_idle, 1);
      check_eq("rst_b_dvalid", any_dv_b(), 0);
      adv();

      // Cap: host0 keeps requesting, device never responds
      a_d_i.a_ready = 1'b1;
      a_h_i[0].a_valid = 1'b1;
      a_h_i[0].a_source = 8'h05;
      a_h_i[0].a_address = 32'h1000;
      a_exp_q.push_back(fwd(8'h05, 0));
      a_exp_q.push_back(fwd(8'h05, 0));
      for (int c = 0; c < 4; c++) begin
         #1;
         check_eq("cap_a_ready", a_h_o[0].a_ready, (c < 2) ? 1 : 0);
         adv();
      end
      check_eq("cap_out", a_out[3:0], 2);
      check_eq("cap_idle", a_idle, 0);
      a_h_i[0].a_valid = 1'b0;

      // Drain host0
      for (int r = 0; r < 2; r++) begin
         a_d_i.d_valid = 1'b1;
         a_d_i.d_source = fwd(8'h05, 0);
         a_h_i[0].d_ready = 1'b1;
         #1;
         check_eq("drain_dvalid", a_h_o[0].d_valid, 1);
         check_eq("drain_dsrc", a_h_o[0].d_source, 8'h05);
         check_eq("drain_dready", a_d_o.d_ready, 1);
         check_eq("drain_other", a_h_o[1].d_valid, 0);
         adv();
      end
      a_d_i.d_valid = 1'b0;
      #1;
      check_eq("drain_out", a_out, 0);
      check_eq("drain_idle", a_idle, 1);
      adv();

      // Response to a host with zero in flight must not underflow
      a_d_i.d_valid = 1'b1;
      a_d_i.d_source = 8'h03;
      a_h_i[3].d_ready = 1'b1;
      #1;
      adv();
      a_d_i.d_valid = 1'b0;
      #1;
      check_eq("underflow_out", a_out, 0);
      adv();

      // Round robin from pointer 0
      do_reset();
      a_d_i.a_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_h_i[i].a_valid = 1'b1;
         a_h_i[i].a_source = 8'h10 + 8'(i);
      end
      for (int c = 0; c < 5; c++) a_exp_q.push_back(fwd(8'h10 + 8'(c % 4), c % 4));
      for (int c = 0; c < 5; c++) begin
         #1;
         check_eq("rr_grant", a_h_o[c % 4].a_ready, 1);
         adv();
      end
      for (int i = 0; i < 4; i++) a_h_i[i].a_valid = 1'b0;
      #1;
      check_eq("rr_out", a_out, 16'h1112);

      // Response to host2 with a same-cycle host2 request
      a_d_i.d_valid = 1'b1;
      a_d_i.d_source = 8'h0A;
      a_h_i[2].d_ready = 1'b1;
      a_h_i[2].a_valid = 1'b1;
      a_h_i[2].a_source = 8'h12;
      a_exp_q.push_back(fwd(8'h12, 2));
      #1;
      check_eq("rsp_dvalid", a_h_o[2].d_valid, 1);
      check_eq("rsp_dsrc", a_h_o[2].d_source, 8'h02);
      check_eq("rsp_other", a_h_o[0].d_valid, 0);
      check_eq("rsp_dready", a_d_o.d_ready, 1);
      check_eq("rsp_aready", a_h_o[2].a_ready, 1);
      adv();
      a_d_i.d_valid = 1'b0;
      a_h_i[2].a_valid = 1'b0;
      #1;
      check_eq("rsp_cnt2", a_out[11:8], 1);
      adv();

      // Lock: stalled host2 keeps the grant while host1 joins
      do_reset();
      a_h_i[2].a_valid = 1'b1;
      a_h_i[2].a_source = 8'h22;
      a_exp_q.push_back(fwd(8'h22, 2));
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            a_h_i[1].a_valid = 1'b1;
            a_h_i[1].a_source = 8'h21;
            a_exp_q.push_back(fwd(8'h21, 1));
         end
         #1;
         check_eq("lock_valid", a_d_o.a_valid, 1);
         check_eq("lock_src", a_d_o.a_source, fwd(8'h22, 2));
         check_eq("lock_h1_ready", a_h_o[1].a_ready, 0);
         adv();
      end
      a_d_i.a_ready = 1'b1;
      #1;
      check_eq("lock_h2_ready", a_h_o[2].a_ready, 1);
      adv();
      #1;
      check_eq("next_h1_ready", a_h_o[1].a_ready, 1);
      check_eq("next_h2_ready", a_h_o[2].a_ready, 0);
      adv();
      a_h_i[1].a_valid = 1'b0;
      a_h_i[2].a_valid = 1'b0;

      // Request register on B: one per cycle, one cycle of latency
      b_d_i.a_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_h_i[i].a_valid = 1'b1;
         b_h_i[i].a_source = 8'h30 + 8'(i);
         b_exp_q.push_back(fwd(8'h30 + 8'(i), i));
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         check_eq("rr1_dvalid", b_d_o.a_valid, (c == 0) ? 0 : 1);
         check_eq("rr1_hready", b_h_o[c].a_ready, 1);
         adv();
         b_h_i[c].a_valid = 1'b0;
      end
      #1;
      check_eq("rr1_tail_valid", b_d_o.a_valid, 1);
      check_eq("rr1_busy", b_idle, 0);
      adv();
      #1;
      check_eq("rr1_empty", b_d_o.a_valid, 0);
      adv();
      for (int k = 0; k < 3; k++) begin
         b_d_i.d_valid = 1'b1;
         b_d_i.d_source = fwd(8'h30 + 8'(k), k);
         b_h_i[k].d_ready = 1'b1;
         #1;
         check_eq("rr1_rsp_dvalid", b_h_o[k].d_valid, 1);
         check_eq("rr1_rsp_dsrc", b_h_o[k].d_source, 8'h30 + 8'(k));
         check_eq("rr1_rsp_dready", b_d_o.d_ready, 1);
         adv();
         b_h_i[k].d_ready = 1'b0;
      end
      b_d_i.d_valid = 1'b0;
      #1;
      check_eq("rr1_idle", b_idle, 1);
      check_eq("rr1_out", b_out, 0);
      adv();

      // Bad ID on M=3: swallowed and sticky until reset
      b_d_i.d_valid = 1'b1;
      b_d_i.d_source = 8'h0B;
      #1;
      check_eq("bad_dready", b_d_o.d_ready, 1);
      check_eq("bad_dvalid", any_dv_b(), 0);
      check_eq("bad_err_pre", b_err, 0);
      adv();
      b_d_i.d_valid = 1'b0;
      #1;
      check_eq("bad_err_set", b_err, 1);
      adv();
      adv();
      adv();
      check_eq("bad_err_hold", b_err, 1);
      check_eq("bad_out", b_out, 0);
      rst_n = 1'b0;
      #1;
      check_eq("bad_err_rst", b_err, 0);

      check_eq("a_sb_left", a_exp_q.size(), 0);
      check_eq("b_sb_left", b_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
